// File: rtl/code_entry_ctrl_pkg.sv
// Shared encodings for the code entry controller and its display.
// Also sizes the shared hold/timeout/lockout timer.
package code_entry_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_SUCCESS = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_FAIL = 2'b01;
  localparam logic [1:0] STAT_OK   = 2'b10;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_entry_ctrl_hold_timer.sv
// Loadable down-counter; done pulses in the last counted cycle.
// A load of N therefore spans exactly N cycles before done fires.
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/code_entry_ctrl.sv
// Four-digit code entry FSM with timeout, result hold and lockout.
// One timer is shared, since only one of those waits is ever live.
module code_entry_ctrl
  import code_entry_ctrl_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned HOLD_CYCLES    = 125000,
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       cancel,
  output logic [1:0] status,
  output logic [3:0] count,
  output logic       locked
);

  localparam int unsigned MAXC =
    max3(HOLD_CYCLES, TIMEOUT_CYCLES, LOCK_CYCLES);
  localparam int TW = $clog2(MAXC + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    status_q, status_d;
  logic [3:0]    count_q, count_d;
  logic          locked_q, locked_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [15:0]   digits_q, digits_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  hold_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    count_d  = count_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    digits_d = digits_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (digit_valid) begin
          digits_d = {12'h000, digit};
          count_d  = 4'd1;
          state_d  = ST_ENTRY;
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES);
        end
      end
      ST_ENTRY: begin
        // Full code stored: evaluate before any new input.
        if (count_q == 4'd4) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYCLES);
          if (digits_q == CODE) begin
            status_d = STAT_OK;
            fail_d   = '0;
            state_d  = ST_SUCCESS;
          end else begin
            status_d = STAT_FAIL;
            if (fail_q != FW'(MAX_FAILS)) begin
              fail_d = fail_q + FW'(1);
            end
            state_d = ST_FAIL;
          end
        end else if (cancel) begin
          count_d = 4'd0;
          state_d = ST_IDLE;
        end else if (digit_valid) begin
          digits_d = {digits_q[11:0], digit};
          count_d  = count_q + 4'd1;
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES);
        end else if (tmr_done) begin
          count_d = 4'd0;
          state_d = ST_IDLE;
        end
      end
      ST_SUCCESS: begin
        if (tmr_done) begin
          status_d = STAT_IDLE;
          count_d  = 4'd0;
          state_d  = ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (tmr_done) begin
          status_d = STAT_IDLE;
          count_d  = 4'd0;
          if (fail_q == FW'(MAX_FAILS)) begin
            locked_d = 1'b1;
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCK_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        status_d = STAT_IDLE;
        count_d  = 4'd0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      status_q <= STAT_IDLE;
      count_q  <= 4'd0;
      locked_q <= 1'b0;
      fail_q   <= '0;
      digits_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      count_q  <= count_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      digits_q <= digits_d;
    end
  end

  assign status = status_q;
  assign count  = count_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl with a queued scoreboard.
// Outputs are sampled 1 time unit after each rising edge.
module tb_code_entry_ctrl;
  import code_entry_ctrl_pkg::*;

  localparam int HOLD = 8;
  localparam int TMO  = 20;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       cancel = 1'b0;
  logic [1:0] status;
  logic [3:0] count;
  logic       locked;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  code_entry_ctrl #(
    .CODE           (16'h1234),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .MAX_FAILS      (3),
    .LOCK_CYCLES    (LOCK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .cancel      (cancel),
    .status      (status),
    .count       (count),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [1:0] st,
                      input logic [3:0] cn, input logic lk);
    exp_q.push_back({st, cn, lk});
    tag_q.push_back(t);
  endtask

  task automatic pop_check();
    logic [6:0] e;
    logic [6:0] o;
    string t;
    n_cmp++;
    o = {status, count, locked};
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: got %h want <entry>", o);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s: got st=%b cnt=%0d lk=%b want st=%b cnt=%0d lk=%b",
               t, o[6:5], o[4:1], o[0], e[6:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic chk_int(input string t, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", t, o, e);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] exp_cnt);
    digit_valid = 1'b1;
    digit = d;
    push("digit_count", STAT_IDLE, exp_cnt, 1'b0);
    tick();
    digit_valid = 1'b0;
    pop_check();
  endtask

  // Enter four digits, check the result, its exact hold length and the exit.
  task automatic attempt(input logic [15:0] code, input logic [1:0] st,
                         input logic lk_after);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] c;
      c = code << (4 * i);
      send(c[15:12], 4'(i + 1));
    end
    push("result", st, 4'd4, 1'b0);
    tick();
    pop_check();
    for (int i = 1; i < HOLD; i++) begin
      push("hold", st, 4'd4, 1'b0);
      tick();
      if (i == HOLD - 1) pop_check();
      else begin
        void'(exp_q.pop_back());
        void'(tag_q.pop_back());
      end
    end
    push("hold_end", STAT_IDLE, 4'd0, lk_after);
    tick();
    pop_check();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    push("reset_async", STAT_IDLE, 4'd0, 1'b0);
    pop_check();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    push("reset_state", STAT_IDLE, 4'd0, 1'b0);
    pop_check();
    reset = 1'b0;
    tick();

    // Correct code
    attempt(16'h1234, STAT_OK, 1'b0);

    // Three failures to lockout, digit ignored while locked
    attempt(16'h1235, STAT_FAIL, 1'b0);
    attempt(16'h1235, STAT_FAIL, 1'b0);
    attempt(16'h1235, STAT_FAIL, 1'b1);
    for (int i = 1; i < LOCK; i++) begin
      digit_valid = (i == 3);
      digit = 4'd1;
      tick();
      if (i == 3 || i == LOCK - 1) begin
        push("lockout", STAT_IDLE, 4'd0, 1'b1);
        pop_check();
      end
    end
    digit_valid = 1'b0;
    push("lock_end", STAT_IDLE, 4'd0, 1'b0);
    tick();
    pop_check();
    chk_int("fail_cnt_after_lock", int'(dut.fail_q), 0);

    // Timeout after a single digit
    send(4'd1, 4'd1);
    for (int i = 1; i < TMO; i++) tick();
    push("pre_timeout", STAT_IDLE, 4'd1, 1'b0);
    pop_check();
    tick();
    push("timeout", STAT_IDLE, 4'd0, 1'b0);
    pop_check();
    attempt(16'h1234, STAT_OK, 1'b0);

    // Cancel beats a simultaneous digit
    send(4'd1, 4'd1);
    send(4'd2, 4'd2);
    cancel = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd3;
    tick();
    cancel = 1'b0;
    digit_valid = 1'b0;
    push("cancel", STAT_IDLE, 4'd0, 1'b0);
    pop_check();
    chk_int("cancel_state", int'(dut.state_q), int'(ST_IDLE));
    attempt(16'h1234, STAT_OK, 1'b0);

    // Reset at the 4th hold cycle
    for (int i = 0; i < 4; i++) begin
      logic [15:0] c;
      c = 16'h1234 << (4 * i);
      send(c[15:12], 4'(i + 1));
    end
    tick();
    push("hold_1", STAT_OK, 4'd4, 1'b0);
    pop_check();
    tick();
    tick();
    tick();
    do_reset();
    attempt(16'h1235, STAT_FAIL, 1'b0);
    chk_int("fail_cnt_after_reset", int'(dut.fail_q), 1);

    // Two failures, success, one failure: no lockout
    do_reset();
    attempt(16'h123A, STAT_FAIL, 1'b0);
    attempt(16'hFFFF, STAT_FAIL, 1'b0);
    attempt(16'h1234, STAT_OK, 1'b0);
    chk_int("fail_cnt_cleared", int'(dut.fail_q), 0);
    attempt(16'h4321, STAT_FAIL, 1'b0);
    chk_int("fail_cnt_one", int'(dut.fail_q), 1);
    for (int i = 0; i < 4; i++) tick();
    push("no_lockout", STAT_IDLE, 4'd0, 1'b0);
    pop_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_entry_ctrl.md
CODE_ENTRY_CTRL -- requirements
Module: code_entry_ctrl

Interface
REQ-001 SHALL have parameter CODE, default 16'h1234: four 4-bit digits of the correct code, first-entered digit in [15:12].
REQ-002 SHALL have parameter HOLD_CYCLES, default 125000: status hold time, 25 ms at 5 MHz.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 25000000: idle-entry abort time, 5 s.
REQ-004 SHALL have parameter MAX_FAILS, default 3: consecutive failures before lockout.
REQ-005 SHALL have parameter LOCK_CYCLES, default 50000000: lockout duration, 10 s.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port digit_valid, input, 1 bit: one-cycle pulse, digit is present.
REQ-009 SHALL have port digit, input, 4 bits: entered digit value, sampled when digit_valid=1.
REQ-010 SHALL have port cancel, input, 1 bit: one-cycle pulse, abandon the current entry.
REQ-011 SHALL have port status, output, 2 bits: 00 idle/entering, 01 failed attempt, 10 successful attempt; 11 never driven.
REQ-012 SHALL have port count, output, 4 bits: digits accepted so far in the current attempt, 0..4.
REQ-013 SHALL have port locked, output, 1 bit: high while in lockout.

Function
REQ-014 SHALL implement states IDLE, ENTRY, SUCCESS, FAIL, LOCKOUT.
REQ-015 SHALL register all outputs; count SHALL update on the cycle after the accepting digit_valid.
REQ-016 IDLE: on digit_valid, SHALL store the digit, set count=1 and go to ENTRY.
REQ-017 ENTRY: each digit_valid SHALL store the digit, increment count and restart the timeout timer.
REQ-018 ENTRY: on the 4th digit, SHALL compare the stored digits with CODE one cycle later.
  - Match: status=10, fail counter cleared, go to SUCCESS.
  - Mismatch: status=01, fail counter incremented (saturating at MAX_FAILS), go to FAIL.
  - count SHALL read 4 while the result is shown.
REQ-019 SUCCESS/FAIL: SHALL hold status for exactly HOLD_CYCLES cycles.
  - Then status=00 and count=0.
  - From FAIL with fail counter == MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
REQ-020 ENTRY: TIMEOUT_CYCLES cycles with no digit_valid SHALL clear count to 0 and return to IDLE; status stays 00 and the fail counter is unchanged.
REQ-021 cancel in ENTRY SHALL clear count and return to IDLE next cycle.
  - If cancel and digit_valid occur in the same cycle, cancel wins and the digit is discarded.
  - cancel in any other state SHALL be ignored.
REQ-022 digit_valid in SUCCESS, FAIL or LOCKOUT SHALL be ignored: no count change, digit not stored.
REQ-023 LOCKOUT: SHALL drive locked=1, status=00, count=0 for LOCK_CYCLES cycles, then clear the fail counter, drop locked and go to IDLE.
REQ-024 digit values 10..15 SHALL be accepted as ordinary digits; they never match a decimal CODE digit.

Reset
REQ-025 reset SHALL act asynchronously and set state=IDLE, status=00, count=0, locked=0, fail counter=0, timer=0 and stored digits=0.
REQ-026 reset asserted mid-hold, mid-entry or mid-lockout SHALL abort the operation with no residual output.
REQ-027 After reset releases, the first digit_valid SHALL be accepted as digit 1.

Structure
REQ-028 SHALL place the state encoding and status codes (STAT_IDLE=00, STAT_FAIL=01, STAT_OK=10) in a shared package also used by Display.
REQ-029 SHALL use one sub-module, hold_timer: a loadable down-counter with a done pulse, width sized for the largest of the cycle parameters, shared by the hold, timeout and lockout functions.

Verification
Bench runs with CODE=16'h1234, HOLD_CYCLES=8, TIMEOUT_CYCLES=20, MAX_FAILS=3, LOCK_CYCLES=16.
REQ-030 Digits 1,2,3,4 -> count steps 1,2,3,4; status=10 for 8 cycles; then status=00, count=0.
REQ-031 Digits 1,2,3,5 entered three times -> status=01 each time; after the 3rd hold, locked=1 for 16 cycles; a digit pulsed during lockout leaves count=0.
REQ-032 Digit 1, then 20 idle cycles -> count returns to 0 with status=00; next digits 1,2,3,4 -> status=10.
REQ-033 Digits 1,2, then cancel and digit_valid in the same cycle -> count=0, state IDLE; digits 1,2,3,4 -> status=10.
REQ-034 Digits 1,2,3,4, then reset pulsed at the 4th hold cycle -> status=00, count=0 immediately; next entry of 1,2,3,5 -> status=01.
REQ-035 Two failures, then a success, then one failure -> no lockout; fail counter=1.
